// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between the icache refill
// path (read-only) and the dcache (reads and writes). Round-robin arbitration,
// a single outstanding transaction, and a watchdog that aborts a stalled
// memory transaction with a bus error.
module mem_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              resetn,
  // icache refill side
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_valid,
  output logic [DATA_W-1:0] ic_rdata,
  // dcache side
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  input  logic [3:0]        dc_wmask,
  output logic              dc_valid,
  output logic [DATA_W-1:0] dc_rdata,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              bus_err
);

  // Watchdog counter only needs to reach TIMEOUT.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic             WD_ON   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IC = 2'd1,
    GNT_DC = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_dc_q, last_dc_d;   // 1 = dcache held the last grant
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;

  logic ic_sel, dc_sel, granted;
  logic timeout, done, abort;

  // Decode the current grant and the completion / abort conditions.
  always_comb begin
    ic_sel  = (state_q == GNT_IC);
    dc_sel  = (state_q == GNT_DC);
    granted = ic_sel | dc_sel;
    // Watchdog fires when the stall count reaches TIMEOUT; a mem_valid in
    // the same cycle still counts as a normal completion.
    timeout = granted & WD_ON & (wd_cnt_q == TO_VAL);
    done    = granted & (mem_valid | timeout);
    abort   = timeout & ~mem_valid;
  end

  // Next-state logic: arbitration in IDLE, completion / watchdog in a grant.
  always_comb begin
    state_d     = state_q;
    last_dc_d   = last_dc_q;
    wd_cnt_d    = wd_cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    unique case (state_q)
      IDLE: begin
        // On a tie the requester that did not hold the last grant wins.
        if (ic_req && (!dc_req || last_dc_q)) begin
          state_d     = GNT_IC;
          last_dc_d   = 1'b0;
          wd_cnt_d    = '0;
          mem_we_d    = 1'b0;
          mem_addr_d  = ic_addr;
          mem_wdata_d = '0;
          mem_wmask_d = 4'b0000;
        end else if (dc_req) begin
          state_d     = GNT_DC;
          last_dc_d   = 1'b1;
          wd_cnt_d    = '0;
          mem_we_d    = dc_we;
          mem_addr_d  = dc_addr;
          mem_wdata_d = dc_wdata;
          mem_wmask_d = dc_wmask;
        end
      end
      GNT_IC, GNT_DC: begin
        // Request lines are ignored here; the registered command is held
        // until the transaction completes or is aborted.
        if (done) begin
          state_d  = IDLE;
          mem_we_d = 1'b0;
          wd_cnt_d = '0;
        end else if (WD_ON) begin
          wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        mem_we_d = 1'b0;
        wd_cnt_d = '0;
      end
    endcase
  end

  // State and registered memory command; reset drops the grant immediately.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      last_dc_q   <= 1'b1;
      wd_cnt_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      last_dc_q   <= last_dc_d;
      wd_cnt_q    <= wd_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

  // Requester-side responses. A requester that dropped its request mid-grant
  // gets no valid (and no bus error) for the transaction it abandoned.
  always_comb begin
    ic_valid = ic_sel & done & ic_req;
    dc_valid = dc_sel & done & dc_req;
    ic_rdata = (ic_sel && mem_valid) ? mem_rdata : '0;
    dc_rdata = (dc_sel && mem_valid) ? mem_rdata : '0;
    bus_err  = abort & ((ic_sel & ic_req) | (dc_sel & dc_req));
  end

  // mem_req follows the state register so an asynchronous reset removes it
  // without waiting for a clock.
  assign mem_req   = granted;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (watchdog TIMEOUT set to 4).
module tb_mem_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          resetn;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_valid;
  logic [DW-1:0] ic_rdata;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic [3:0]    dc_wmask;
  logic          dc_valid;
  logic [DW-1:0] dc_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic [DW-1:0] mem_rdata;
  logic          mem_valid;
  logic          bus_err;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
    .CLK(CLK), .resetn(resetn),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_valid(ic_valid), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wmask(dc_wmask), .dc_valid(dc_valid), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .bus_err(bus_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the drive point of the next cycle (just after the rising edge).
  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  // Move to the sampling point of the current cycle (falling edge).
  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    nxt();
    nxt();
    resetn = 1'b1;
  endtask

  initial begin
    resetn    = 1'b0;
    ic_req    = 1'b0;
    ic_addr   = '0;
    dc_req    = 1'b0;
    dc_we     = 1'b0;
    dc_addr   = '0;
    dc_wdata  = '0;
    dc_wmask  = 4'b0000;
    mem_rdata = '0;
    mem_valid = 1'b0;

    // Reset state
    nxt(); nxt();
    smp();
    chk("rst_mem_req",   mem_req,   0);
    chk("rst_mem_we",    mem_we,    0);
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_ic_valid",  ic_valid,  0);
    chk("rst_dc_valid",  dc_valid,  0);
    chk("rst_bus_err",   bus_err,   0);
    nxt();
    resetn = 1'b1;

    // Single icache read: request at cycle 1, mem_valid at cycle 4
    nxt();                                   // cycle 1
    ic_req = 1'b1; ic_addr = 20'h00104;
    smp(); chk("ic1_c1_mem_req", mem_req, 0);
    nxt(); smp();                            // cycle 2
    chk("ic1_c2_mem_req", mem_req, 1);
    chk("ic1_c2_mem_addr", mem_addr, 20'h00104);
    chk("ic1_c2_mem_we", mem_we, 0);
    nxt(); smp();                            // cycle 3
    chk("ic1_c3_mem_req", mem_req, 1);
    chk("ic1_c3_ic_valid", ic_valid, 0);
    nxt();                                   // cycle 4
    mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    smp();
    chk("ic1_c4_mem_req", mem_req, 1);
    chk("ic1_c4_ic_valid", ic_valid, 1);
    chk("ic1_c4_ic_rdata", ic_rdata, 32'hDEADBEEF);
    chk("ic1_c4_dc_valid", dc_valid, 0);
    chk("ic1_c4_dc_rdata", dc_rdata, 0);
    chk("ic1_c4_bus_err", bus_err, 0);
    nxt();                                   // cycle 5
    ic_req = 1'b0; mem_valid = 1'b0;
    smp();
    chk("ic1_c5_mem_req", mem_req, 0);
    chk("ic1_c5_ic_valid", ic_valid, 0);

    // Tie after reset: icache first, one idle bubble, then dcache
    do_reset();
    ic_req = 1'b1; ic_addr = 20'h00A00;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 20'h00B00;
    smp(); chk("tie_idle_mem_req", mem_req, 0);
    nxt();
    mem_valid = 1'b1; mem_rdata = 32'h0000AAAA;
    smp();
    chk("tie1_mem_addr", mem_addr, 20'h00A00);
    chk("tie1_ic_valid", ic_valid, 1);
    chk("tie1_dc_valid", dc_valid, 0);
    nxt();
    ic_req = 1'b0; mem_valid = 1'b0;
    smp(); chk("tie_bubble_mem_req", mem_req, 0);
    nxt();
    mem_valid = 1'b1; mem_rdata = 32'h0000BBBB;
    smp();
    chk("tie2_mem_req", mem_req, 1);
    chk("tie2_mem_addr", mem_addr, 20'h00B00);
    chk("tie2_dc_valid", dc_valid, 1);
    chk("tie2_dc_rdata", dc_rdata, 32'h0000BBBB);
    chk("tie2_ic_rdata", ic_rdata, 0);
    nxt();
    dc_req = 1'b0; mem_valid = 1'b0;
    smp(); chk("tie2_done_mem_req", mem_req, 0);
    nxt();
    ic_req = 1'b1; dc_req = 1'b1;            // second tie -> icache again
    nxt();
    mem_valid = 1'b1; mem_rdata = 32'h0000CCCC;
    smp();
    chk("tie3_mem_addr", mem_addr, 20'h00A00);
    chk("tie3_ic_valid", ic_valid, 1);
    nxt();
    ic_req = 1'b0; dc_req = 1'b0; mem_valid = 1'b0;
    nxt();

    // Dcache write; command registered at grant and held while inputs move
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 20'h0FFFC;
    dc_wdata = 32'h12345678; dc_wmask = 4'b0011;
    nxt();
    dc_addr = 20'h00000; dc_wdata = 32'h0; dc_wmask = 4'b1111;
    smp();
    chk("wr_mem_req", mem_req, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 20'h0FFFC);
    chk("wr_mem_wdata", mem_wdata, 32'h12345678);
    chk("wr_mem_wmask", mem_wmask, 4'b0011);
    nxt();
    mem_valid = 1'b1;
    smp();
    chk("wr_hold_mem_addr", mem_addr, 20'h0FFFC);
    chk("wr_dc_valid", dc_valid, 1);
    chk("wr_ic_valid", ic_valid, 0);
    nxt();
    dc_req = 1'b0; dc_we = 1'b0; mem_valid = 1'b0;
    smp();
    chk("wr_done_mem_req", mem_req, 0);
    chk("wr_done_mem_we", mem_we, 0);
    nxt();

    // Watchdog: no mem_valid, abort 4 cycles after the grant
    dc_req = 1'b1; dc_addr = 20'h00200; mem_rdata = 32'hCAFEF00D;
    nxt(); smp(); chk("wd_g0_mem_req", mem_req, 1);
    nxt(); nxt(); nxt(); smp();
    chk("wd_g3_dc_valid", dc_valid, 0);
    chk("wd_g3_bus_err", bus_err, 0);
    chk("wd_g3_mem_req", mem_req, 1);
    nxt(); smp();
    chk("wd_g4_dc_valid", dc_valid, 1);
    chk("wd_g4_bus_err", bus_err, 1);
    chk("wd_g4_dc_rdata", dc_rdata, 0);
    nxt();
    dc_req = 1'b0;
    smp();
    chk("wd_after_mem_req", mem_req, 0);
    chk("wd_after_bus_err", bus_err, 0);
    nxt();

    // Watchdog: mem_valid on the timeout cycle completes normally
    dc_req = 1'b1;
    nxt(); nxt(); nxt(); nxt(); nxt();
    mem_valid = 1'b1;
    smp();
    chk("wdv_dc_valid", dc_valid, 1);
    chk("wdv_bus_err", bus_err, 0);
    chk("wdv_dc_rdata", dc_rdata, 32'hCAFEF00D);
    nxt();
    dc_req = 1'b0; mem_valid = 1'b0;
    smp(); chk("wdv_after_mem_req", mem_req, 0);
    nxt();

    // Requester drops request mid-grant: transaction completes, no valid
    ic_req = 1'b1; ic_addr = 20'h00150;
    nxt();
    ic_req = 1'b0;
    nxt();
    mem_valid = 1'b1;
    smp();
    chk("drop_mem_req", mem_req, 1);
    chk("drop_ic_valid", ic_valid, 0);
    nxt();
    mem_valid = 1'b0;
    smp(); chk("drop_after_mem_req", mem_req, 0);
    nxt();

    // Reset in the middle of an icache grant
    ic_req = 1'b1; ic_addr = 20'h00300;
    nxt(); smp();
    chk("rmid_mem_req_before", mem_req, 1);
    nxt();
    resetn = 1'b0;
    #1;
    chk("rmid_mem_req", mem_req, 0);
    chk("rmid_mem_addr", mem_addr, 0);
    chk("rmid_mem_we", mem_we, 0);
    chk("rmid_ic_valid", ic_valid, 0);
    chk("rmid_bus_err", bus_err, 0);
    nxt();
    resetn = 1'b1;
    nxt();
    mem_valid = 1'b1; mem_rdata = 32'h00001111;
    smp();
    chk("rpost_mem_req", mem_req, 1);
    chk("rpost_mem_addr", mem_addr, 20'h00300);
    chk("rpost_ic_valid", ic_valid, 1);
    chk("rpost_ic_rdata", ic_rdata, 32'h00001111);
    nxt();
    ic_req = 1'b0; mem_valid = 1'b0;
    smp(); chk("rpost_done_mem_req", mem_req, 0);
    nxt();

    // Back-to-back streams: last grant was icache, so dcache goes first
    ic_req = 1'b1; ic_addr = 20'h00500;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 20'h00400;
    for (int i = 0; i < 4; i++) begin
      logic exp_dc;
      exp_dc = (i % 2 == 0);
      nxt();
      if (i > 0) begin
        if (exp_dc) ic_req = 1'b1;
        else        dc_req = 1'b1;
      end
      smp();
      chk("bb_mem_req", mem_req, 1);
      chk("bb_mem_addr", mem_addr, exp_dc ? 20'h00400 : 20'h00500);
      nxt();
      mem_valid = 1'b1; mem_rdata = 32'h100 + i;
      smp();
      chk("bb_hold_mem_addr", mem_addr, exp_dc ? 20'h00400 : 20'h00500);
      chk("bb_dc_valid", dc_valid, exp_dc);
      chk("bb_ic_valid", ic_valid, !exp_dc);
      chk("bb_dc_rdata", dc_rdata, exp_dc ? 32'h100 + i : 32'h0);
      chk("bb_ic_rdata", ic_rdata, exp_dc ? 32'h0 : 32'h100 + i);
      nxt();
      mem_valid = 1'b0;
      if (exp_dc) dc_req = 1'b0;
      else        ic_req = 1'b0;
      smp();
      chk("bb_bubble_mem_req", mem_req, 0);
    end
    ic_req = 1'b0; dc_req = 1'b0;
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
